// File: rtl/asic_function_interface_ctrl.sv
// Serial transaction controller: shifts a 32-bit operand out to an external ASIC,
// waits (bounded) for its ready flag, then shifts the 32-bit result back in.
module asic_function_interface_ctrl #(
  parameter int CLK_DIV        = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] asic_data_out,
  output logic [31:0] asic_data_in,
  output logic        done,
  output logic        busy,
  output logic        timeout_err,
  output logic        asic_cs_n,
  output logic        asic_sclk,
  output logic        asic_mosi,
  input  logic        asic_miso,
  input  logic        asic_ready
);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_OUT,
    WAIT_READY,
    SHIFT_IN,
    DONE
  } state_t;

  localparam int                WAIT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [7:0]        DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  state_t            state_q;
  logic [7:0]        div_q;
  logic              sclk_q;
  logic [5:0]        bit_cnt_q;
  logic [WAIT_W-1:0] wait_q;
  logic [31:0]       tx_q;
  logic [31:0]       rx_q;
  logic [31:0]       data_in_q;
  logic              done_q;
  logic              timeout_q;
  logic              cs_n_q;
  logic              ready_meta_q;
  logic              ready_sync_q;

  logic              div_wrap;
  logic [7:0]        div_d;

  assign div_wrap = (div_q == DIV_LAST);
  assign div_d    = div_wrap ? 8'd0 : div_q + 8'd1;

  // NOTE: every register, including the shift registers, is reset so an abort
  // leaves no stale operand or partial result visible to software.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      div_q        <= '0;
      sclk_q       <= 1'b0;
      bit_cnt_q    <= '0;
      wait_q       <= '0;
      tx_q         <= '0;
      rx_q         <= '0;
      data_in_q    <= '0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      cs_n_q       <= 1'b1;
      ready_meta_q <= 1'b0;
      ready_sync_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // pre-edge values of the state it is updating.
      ready_meta_q <= asic_ready;
      ready_sync_q <= ready_meta_q;

      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            tx_q      <= asic_data_out;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            cs_n_q    <= 1'b0;
            div_q     <= '0;
            sclk_q    <= 1'b0;
            bit_cnt_q <= '0;
            state_q   <= SHIFT_OUT;
          end
        end

        SHIFT_OUT: begin
          div_q <= div_d;
          if (div_wrap) begin
            sclk_q <= ~sclk_q;
            // Falling SCLK: the ASIC has sampled the current bit, present the next.
            if (sclk_q) begin
              tx_q      <= {tx_q[30:0], 1'b0};
              bit_cnt_q <= bit_cnt_q + 6'd1;
              if (bit_cnt_q == 6'd31) begin
                wait_q  <= '0;
                state_q <= WAIT_READY;
              end
            end
          end
        end

        WAIT_READY: begin
          if (ready_sync_q) begin
            div_q     <= '0;
            sclk_q    <= 1'b0;
            bit_cnt_q <= '0;
            rx_q      <= '0;
            state_q   <= SHIFT_IN;
          end else if (wait_q == WAIT_LAST) begin
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
            cs_n_q    <= 1'b1;
            state_q   <= DONE;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end

        SHIFT_IN: begin
          div_q <= div_d;
          if (div_wrap) begin
            if (!sclk_q) begin
              sclk_q    <= 1'b1;
              rx_q      <= {rx_q[30:0], asic_miso};
              bit_cnt_q <= bit_cnt_q + 6'd1;
            end else begin
              sclk_q <= 1'b0;
              if (bit_cnt_q == 6'd32) begin
                data_in_q <= rx_q;
                done_q    <= 1'b1;
                cs_n_q    <= 1'b1;
                state_q   <= DONE;
              end
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign asic_data_in = data_in_q;
  assign done         = done_q;
  assign timeout_err  = timeout_q;
  assign asic_cs_n    = cs_n_q;
  assign asic_sclk    = sclk_q;
  assign asic_mosi    = (state_q == SHIFT_OUT) && !cs_n_q && tx_q[31];
  assign busy         = (state_q == SHIFT_OUT) || (state_q == WAIT_READY) || (state_q == SHIFT_IN);

endmodule

// File: tb/tb_asic_function_interface_ctrl.sv
// Directed bench with a behavioural ASIC model and a queue-based scoreboard.
module tb_asic_function_interface_ctrl;

  localparam int CLK_DIV = 2;
  localparam int TMO     = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] asic_data_out;
  logic [31:0] asic_data_in;
  logic        done, busy, timeout_err;
  logic        asic_cs_n, asic_sclk, asic_mosi;
  logic        asic_miso  = 1'b0;
  logic        asic_ready = 1'b0;

  asic_function_interface_ctrl #(.CLK_DIV(CLK_DIV), .TIMEOUT_CYCLES(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .asic_data_out(asic_data_out),
    .asic_data_in (asic_data_in),
    .done         (done),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .asic_cs_n    (asic_cs_n),
    .asic_sclk    (asic_sclk),
    .asic_mosi    (asic_mosi),
    .asic_miso    (asic_miso),
    .asic_ready   (asic_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] tx;
    logic [31:0] rx;
    logic        tmo;
    int          rises;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad   = 0;
  time         t_done;

  // ASIC model state, sampled on the falling system clock edge
  logic        ready_en = 1'b0;
  logic [31:0] resp     = '0;
  logic [31:0] resp_sh  = '0;
  logic [31:0] mosi_word = '0;
  int          rise_cnt = 0;
  int          fall_cnt = 0;
  int          ready_dly = 0;
  time         t_shift_end = 0;
  logic        prev_cs_n = 1'b1;
  logic        prev_sclk = 1'b0;

  always @(negedge clk) begin
    if (prev_cs_n && !asic_cs_n) begin
      rise_cnt  = 0;
      fall_cnt  = 0;
      mosi_word = '0;
    end
    if (!prev_cs_n && asic_cs_n) begin
      asic_ready = 1'b0;
      asic_miso  = 1'b0;
      ready_dly  = 0;
    end
    if (!asic_cs_n) begin
      if (!prev_sclk && asic_sclk) begin
        if (rise_cnt < 32) mosi_word = {mosi_word[30:0], asic_mosi};
        rise_cnt++;
      end
      if (prev_sclk && !asic_sclk) begin
        fall_cnt++;
        if (fall_cnt == 32) begin
          t_shift_end = $time - 5;
          if (ready_en) ready_dly = 10;
        end else if (fall_cnt > 32) begin
          resp_sh   = {resp_sh[30:0], 1'b0};
          asic_miso = resp_sh[31];
        end
      end
      if (ready_dly > 0) begin
        ready_dly--;
        if (ready_dly == 0) begin
          resp_sh    = resp;
          asic_miso  = resp[31];
          asic_ready = 1'b1;
        end
      end
    end
    prev_cs_n = asic_cs_n;
    prev_sclk = asic_sclk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [31:0] d);
    asic_data_out = d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    @(negedge clk);
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++;
    assert (done === 1'b1)
    else begin
      bad++;
      $error("FAIL done_wait observed=%b expected=1", done);
    end
    t_done = $time - 5;
  endtask

  task automatic finish_txn();
    exp_t e;
    wait_done(2000);
    e = sb_q.pop_front();
    check("data_in",   asic_data_in, e.rx);
    check("timeout",   32'(timeout_err), 32'(e.tmo));
    check("mosi_word", mosi_word, e.tx);
    check("sclk_rise", rise_cnt, e.rises);
    check("cs_n_end",  32'(asic_cs_n), 32'd1);
    check("sclk_end",  32'(asic_sclk), 32'd0);
    check("mosi_end",  32'(asic_mosi), 32'd0);
    check("busy_end",  32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    asic_data_out = '0;
    repeat (3) @(negedge clk);
    check("rst_cs_n",    32'(asic_cs_n), 32'd1);
    check("rst_sclk",    32'(asic_sclk), 32'd0);
    check("rst_mosi",    32'(asic_mosi), 32'd0);
    check("rst_done",    32'(done), 32'd0);
    check("rst_busy",    32'(busy), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    check("rst_data_in", asic_data_in, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Normal transaction, with a second start ignored during SHIFT_OUT
    ready_en = 1'b1;
    resp = 32'h1234_5678;
    sb_q.push_back('{tx: 32'hA5A5_0F0F, rx: 32'h1234_5678, tmo: 1'b0, rises: 64});
    do_start(32'hA5A5_0F0F);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_cs_n", 32'(asic_cs_n), 32'd0);
    repeat (20) @(negedge clk);
    do_start(32'hFFFF_0000);
    check("t1_ign_busy", 32'(busy), 32'd1);
    check("t1_ign_cs_n", 32'(asic_cs_n), 32'd0);
    finish_txn();

    // Timeout: ready never asserted, start issued from DONE
    ready_en = 1'b0;
    sb_q.push_back('{tx: 32'hA5A5_0F0F, rx: 32'h1234_5678, tmo: 1'b1, rises: 32});
    do_start(32'hA5A5_0F0F);
    check("t2_done_drop", 32'(done), 32'd0);
    check("t2_tmo_clear", 32'(timeout_err), 32'd0);
    finish_txn();
    check("t2_tmo_time", 32'(t_done - t_shift_end), 32'(TMO * 10));

    // Reset mid SHIFT_IN after 16 result bits
    ready_en = 1'b1;
    resp = 32'hDEAD_BEEF;
    do_start(32'h3C3C_C3C3);
    for (int n = 0; n < 2000 && rise_cnt < 48; n++) @(negedge clk);
    check("t3_reached_bit16", 32'(rise_cnt >= 48), 32'd1);
    rst = 1'b1;
    #1;
    check("t3_cs_n",    32'(asic_cs_n), 32'd1);
    check("t3_sclk",    32'(asic_sclk), 32'd0);
    check("t3_done",    32'(done), 32'd0);
    check("t3_data_in", asic_data_in, 32'd0);
    check("t3_busy",    32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // First start after reset is accepted immediately
    resp = 32'h0F1E_2D3C;
    sb_q.push_back('{tx: 32'h1357_9BDF, rx: 32'h0F1E_2D3C, tmo: 1'b0, rises: 64});
    do_start(32'h1357_9BDF);
    check("t4_busy", 32'(busy), 32'd1);
    finish_txn();

    // Back-to-back: start in DONE
    resp = 32'hCAFE_F00D;
    sb_q.push_back('{tx: 32'h2468_ACE0, rx: 32'hCAFE_F00D, tmo: 1'b0, rises: 64});
    do_start(32'h2468_ACE0);
    check("t5_done_drop", 32'(done), 32'd0);
    finish_txn();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/asic_function_interface_ctrl.md
ASIC_FUNCTION_INTERFACE_CTRL -- requirements
Module: asic_function_interface_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, system clocks per SCLK half-period (legal 2..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096, maximum clocks spent in WAIT_READY.
REQ-003 SHALL have port clk, input, 1, the single clock, shared with the AXI register block.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, one-cycle start pulse (ctrl bit 0 from the register block).
REQ-006 SHALL have port asic_data_out, input, 32, operand to send to the ASIC.
REQ-007 SHALL have port asic_data_in, output, 32, last result received from the ASIC.
REQ-008 SHALL have port done, output, 1, level: last transaction finished (feeds ctrl bit 1).
REQ-009 SHALL have port busy, output, 1, high in every state except IDLE and DONE.
REQ-010 SHALL have port timeout_err, output, 1, last transaction aborted by timeout.
REQ-011 SHALL have port asic_cs_n, output, 1, active-low chip select.
REQ-012 SHALL have port asic_sclk, output, 1, serial clock, idle low.
REQ-013 SHALL have port asic_mosi, output, 1, serial data to the ASIC.
REQ-014 SHALL have port asic_miso, input, 1, serial data from the ASIC, synchronous to asic_sclk.
REQ-015 SHALL have port asic_ready, input, 1, asynchronous, ASIC result-available flag.

Function
REQ-016 SHALL implement FSM states IDLE, SHIFT_OUT, WAIT_READY, SHIFT_IN, DONE.
REQ-017 IDLE/DONE + start=1 -> capture asic_data_out into tx shift register, clear done and timeout_err, drive cs_n=0, enter SHIFT_OUT on the next edge.
REQ-018 start SHALL be ignored while busy=1; no state, data or output change.
REQ-019 Divider counter SHALL count 0..CLK_DIV-1 in shift states only; sclk toggles on each wrap; counter and sclk SHALL be 0 on entry to every shift state.
REQ-020 SHIFT_OUT: mosi = tx bit 31 on entry; SCLK rising edge marks ASIC sample; tx shifts left one bit on each SCLK falling edge; MSB first.
REQ-021 SHIFT_OUT SHALL end after the 32nd SCLK falling edge (64*CLK_DIV clocks), with sclk=0, mosi=0, cs_n held 0, then enter WAIT_READY.
REQ-022 asic_ready SHALL pass through a 2-flop synchronizer; WAIT_READY exits to SHIFT_IN on the first clock the synchronized value is 1.
REQ-023 WAIT_READY SHALL count clocks from 0; when the count reaches TIMEOUT_CYCLES-1 without ready, go to DONE with timeout_err=1, asic_data_in unchanged.
REQ-024 SHIFT_IN: asic_miso SHALL be sampled into rx shift register (left shift, MSB first) in the clock where sclk rises; 32 samples, 64*CLK_DIV clocks.
REQ-025 On SHIFT_IN completion: asic_data_in <= rx register, done <= 1, cs_n <= 1, sclk=0, enter DONE; all in the same edge.
REQ-026 DONE SHALL hold done=1, asic_data_in and timeout_err stable until the next accepted start.
REQ-027 Timeout path SHALL also set done=1 and cs_n=1 in the same edge it enters DONE.
REQ-028 Bit counter SHALL be 6 bits, 0..32, reset on every shift-state entry; no wrap beyond 32.
REQ-029 Total nominal latency start->done SHALL be 1 + 64*CLK_DIV + (ready wait + 2 sync) + 64*CLK_DIV clocks.
REQ-030 mosi SHALL be 0 whenever cs_n=1 or state is not SHIFT_OUT.

Reset
REQ-031 rst=1 SHALL asynchronously force state IDLE, cs_n=1, sclk=0, mosi=0, done=0, busy=0, timeout_err=0, asic_data_in=0, all counters and shift registers 0.
REQ-032 rst asserted mid-transaction SHALL abort immediately (cs_n=1 in the same cycle); no result is written.
REQ-033 After rst deasserts, the first start SHALL be accepted on the next clock edge.

Verification (CLK_DIV=2, TIMEOUT_CYCLES=64)
REQ-034 asic_data_out=32'hA5A5_0F0F, start pulse, ASIC model asserts ready 10 clocks after cs_n stays low post-shift and returns 32'h1234_5678 -> mosi bit stream A5A50F0F MSB first on SCLK rising edges, asic_data_in=32'h1234_5678, done=1, timeout_err=0.
REQ-035 Same stimulus, ready never asserted -> done=1, timeout_err=1 exactly 64 clocks after WAIT_READY entry, asic_data_in unchanged from previous value, cs_n=1.
REQ-036 Second start pulse during SHIFT_OUT with different asic_data_out -> ignored; transmitted word is the first operand.
REQ-037 rst pulse during SHIFT_IN at bit 16 -> cs_n=1, sclk=0, done=0, asic_data_in=0 immediately; new start completes normally.
REQ-038 Two back-to-back transactions, start issued in DONE -> done drops the clock after start, rises again with second result; SCLK counts exactly 64 rising edges per transaction.
